chip8_reset_ctrl: RTL and testbench

Parametrised reset-pulse generator for the Chip-8 core, replacing the fixed two-source, fixed-length reset counter in the MiST top level. It merges any number of asynchronous trigger sources (upload-done, OSD button, …) with a software request and power-on, synchronises them, and emits a stretched, retriggerable reset pulse on `rst_out`. It also records which sources caused the pulse. It runs in the slow `clk_12k` domain and drives the `res` input of the chip8 machine.

---
 rtl/chip8_reset_pkg.sv | 25 ++
 rtl/util_sync_edge.sv | 44 ++++
 rtl/chip8_reset_ctrl.sv | 140 ++++++++++++++
 tb/tb_chip8_reset_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_reset_pkg.sv
//==============================================================================
// Module      : chip8_reset_pkg
// Description : Shared state encoding and cause-bit indices for the Chip-8
//               reset-pulse generator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package chip8_reset_pkg;

    // Controller states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Bit positions inside rst_cause.
    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_SW   = 1;
    localparam int CAUSE_SRC0 = 2;

endpackage

`default_nettype wire

// File: rtl/util_sync_edge.sv
//==============================================================================
// Module      : util_sync_edge
// Description : Multi-stage synchroniser followed by a registered edge
//               detector of selectable polarity. Generalises the old
//               util_posedge / util_negedge helpers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module util_sync_edge #(
    parameter int   STAGES = 2,     // synchroniser depth, 2..4
    parameter logic POL    = 1'b1   // 1 = rising edge / active high
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,           // synchronised level, aligned with o_edge
    output logic o_edge             // one-cycle pulse on the active edge
);

    logic [STAGES-1:0] r_sync;
    logic              r_last;
    logic              r_edge;

    // Synchroniser chain plus edge detection; every flop resets to the
    // inactive level so that releasing reset cannot look like an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {STAGES{~POL}};
            r_last <= ~POL;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_last <= r_sync[STAGES-1];
            r_edge <= (r_sync[STAGES-1] == POL) && (r_last != POL);
        end
    end

    assign o_level = r_last;
    assign o_edge  = r_edge;

endmodule

`default_nettype wire

// File: rtl/chip8_reset_ctrl.sv
//==============================================================================
// Module      : chip8_reset_ctrl
// Description : Retriggerable, stretched reset-pulse generator for the Chip-8
//               core. Merges synchronised trigger sources, a software request
//               and power-on, and records the cause of every pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module chip8_reset_ctrl #(
    parameter int                 NUM_SRC     = 2,
    parameter int                 PULSE_LEN   = 16,
    parameter logic [NUM_SRC-1:0] EDGE_POL    = 2'b10,
    parameter logic [NUM_SRC-1:0] HOLD_MASK   = 2'b00,
    parameter int                 SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_res,
    input  logic [NUM_SRC-1:0] i_src,
    input  logic               i_sw_req,
    input  logic               i_cause_clr,
    output logic               o_rst_out,
    output logic               o_rst_done,
    output logic [NUM_SRC+1:0] o_rst_cause
);

    import chip8_reset_pkg::*;

    localparam int               CNT_W   = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PULSE_LEN - 1);
    localparam logic [NUM_SRC+1:0] CAUSE_RST = (NUM_SRC+2)'(1) << CAUSE_POR;

    logic [NUM_SRC-1:0] w_level;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_active;
    logic               w_hold_active;
    logic [NUM_SRC:0]   w_trig_vec;
    logic               w_trig;
    logic               w_nonheld_trig;
    logic [NUM_SRC+1:0] w_trig_cause;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [NUM_SRC+1:0] r_cause;
    logic [NUM_SRC+1:0] w_cause_nxt;
    logic               r_rst_out;
    logic               r_done;
    logic               w_leave;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            util_sync_edge #(
                .STAGES (SYNC_STAGES),
                .POL    (EDGE_POL[i])
            ) u_sync (
                .i_clk   (i_clk),
                .i_rst   (i_res),
                .i_async (i_src[i]),
                .o_level (w_level[i]),
                .o_edge  (w_edge[i])
            );
        end
    endgenerate

    assign w_active       = ~(w_level ^ EDGE_POL);
    assign w_hold_active  = |(w_active & HOLD_MASK);
    assign w_trig_vec     = {w_edge, i_sw_req};
    assign w_trig         = |w_trig_vec;
    assign w_nonheld_trig = i_sw_req | (|(w_edge & ~HOLD_MASK));
    assign w_trig_cause   = {w_trig_vec, 1'b0};

    // Next-state, counter and cause-flag logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cause_nxt = r_cause;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = '0;
                    w_cause_nxt = w_trig_cause;
                end else if (i_cause_clr) begin
                    w_cause_nxt = '0;
                end
            end
            ST_PULSE: begin
                if (w_trig) begin
                    w_cnt_nxt   = '0;
                    w_cause_nxt = r_cause | w_trig_cause;
                end else if (r_cnt == CNT_MAX) begin
                    // Counter stays at its maximum; it never wraps.
                    w_state_nxt = w_hold_active ? ST_HOLD : ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                w_cause_nxt = r_cause | w_trig_cause;
                if (w_nonheld_trig) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = '0;
                end else if (!w_hold_active) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_leave = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

    // State, counter, cause and registered outputs; reset starts a pulse.
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_state   <= ST_PULSE;
            r_cnt     <= '0;
            r_cause   <= CAUSE_RST;
            r_rst_out <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cause   <= w_cause_nxt;
            r_rst_out <= (w_state_nxt != ST_IDLE);
            r_done    <= w_leave;
        end
    end

    assign o_rst_out   = r_rst_out;
    assign o_rst_done  = r_done;
    assign o_rst_cause = r_cause;

endmodule

`default_nettype wire

// File: tb/tb_chip8_reset_ctrl.sv
//==============================================================================
// Module      : tb_chip8_reset_ctrl
// Description : Directed self-checking bench for chip8_reset_ctrl with three
//               configurations: defaults, held source 1, and a 4-source
//               2-cycle-pulse variant with a 3-stage synchroniser.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_chip8_reset_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res;
    logic [1:0] src_a, src_b;
    logic [3:0] src_c;
    logic       sw_a, sw_b, sw_c, clr_a, clr_b, clr_c;
    logic       ro_a, ro_b, ro_c, rd_a, rd_b, rd_c;
    logic [3:0] cause_a, cause_b;
    logic [5:0] cause_c;

    chip8_reset_ctrl u_dut_a (
        .i_clk(clk), .i_res(res), .i_src(src_a), .i_sw_req(sw_a),
        .i_cause_clr(clr_a), .o_rst_out(ro_a), .o_rst_done(rd_a),
        .o_rst_cause(cause_a)
    );

    chip8_reset_ctrl #(.HOLD_MASK(2'b10)) u_dut_b (
        .i_clk(clk), .i_res(res), .i_src(src_b), .i_sw_req(sw_b),
        .i_cause_clr(clr_b), .o_rst_out(ro_b), .o_rst_done(rd_b),
        .o_rst_cause(cause_b)
    );

    chip8_reset_ctrl #(
        .NUM_SRC(4), .PULSE_LEN(2), .EDGE_POL(4'b1111),
        .HOLD_MASK(4'b0000), .SYNC_STAGES(3)
    ) u_dut_c (
        .i_clk(clk), .i_res(res), .i_src(src_c), .i_sw_req(sw_c),
        .i_cause_clr(clr_c), .o_rst_out(ro_c), .o_rst_done(rd_c),
        .o_rst_cause(cause_c)
    );

    // Observation mux over the three instances.
    int         sel;
    logic       ro, rd;
    logic [7:0] cause;
    always_comb begin
        ro    = 1'b0;
        rd    = 1'b0;
        cause = '0;
        case (sel)
            0:       begin ro = ro_a; rd = rd_a; cause = {4'b0, cause_a}; end
            1:       begin ro = ro_b; rd = rd_b; cause = {4'b0, cause_b}; end
            default: begin ro = ro_c; rd = rd_c; cause = {2'b0, cause_c}; end
        endcase
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tick until rst_out is high; lat = number of rising edges taken.
    task automatic wait_rise(output int lat);
        lat = 0;
        while (!ro && lat < 200) begin
            @(negedge clk);
            lat++;
            sw_a = 1'b0; sw_b = 1'b0; sw_c = 1'b0;
        end
    endtask

    // Count samples with rst_out high until it drops; d = rst_done then.
    task automatic run_high(input bit incl_now, output int n, output logic d);
        n = (incl_now && ro) ? 1 : 0;
        for (int i = 0; i < 300; i++) begin
            if (!ro) break;
            @(negedge clk);
            if (ro) n++;
        end
        d = rd;
    endtask

    int   lat, n, hc;
    logic d;

    initial begin
        res = 1'b1; src_a = 2'b01; src_b = 2'b01; src_c = 4'b0000;
        sw_a = 0; sw_b = 0; sw_c = 0; clr_a = 0; clr_b = 0; clr_c = 0;
        sel = 0;
        repeat (3) @(negedge clk);

        // Reset values on all three instances
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk("rst_out_in_res", 32'(ro), 1);
            chk("rst_done_in_res", 32'(rd), 0);
            chk("cause_in_res", 32'(cause), 1);
        end
        sel = 0; #1;

        // Power-on pulse
        res = 1'b0;
        run_high(1, n, d);
        chk("por_len", n, 16);
        chk("por_done", 32'(d), 1);
        chk("por_cause", 32'(cause), 4'b0001);
        @(negedge clk);
        chk("done_one_cycle", 32'(rd), 0);

        // cause_clr in IDLE
        clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
        chk("clr_idle", 32'(cause), 0);

        // src[0] falling edge (upload done)
        src_a[0] = 1'b0;
        wait_rise(lat);
        chk("src0_lat", lat, 4);
        run_high(1, n, d);
        chk("src0_len", n, 16);
        chk("src0_done", 32'(d), 1);
        chk("src0_cause", 32'(cause), 4'b0100);

        // src[0] rising edge does nothing
        src_a[0] = 1'b1; hc = 0;
        repeat (10) begin @(negedge clk); hc += int'(ro); end
        chk("src0_rise_ignored", hc, 0);

        // sw_req and cause_clr together in IDLE: trigger wins
        sw_a = 1'b1; clr_a = 1'b1; @(negedge clk); sw_a = 1'b0; clr_a = 1'b0;
        chk("sw_vs_clr_out", 32'(ro), 1);
        chk("sw_vs_clr_cause", 32'(cause), 4'b0010);
        run_high(1, n, d);
        chk("sw_len", n, 16);
        @(negedge clk);

        // Retrigger: sw_req at cnt 0, src[1] edge reaching the FSM at cnt 10
        sw_a = 1'b1; @(negedge clk); sw_a = 1'b0;
        repeat (7) @(negedge clk);
        src_a[1] = 1'b1;
        run_high(1, n, d);
        chk("retrig_len", n + 7, 27);
        chk("retrig_cause", 32'(cause), 4'b1010);
        src_a[1] = 1'b0; hc = 0;
        repeat (6) begin @(negedge clk); hc += int'(ro); end
        chk("src1_fall_ignored", hc, 0);

        // cause_clr ignored in PULSE, then res at cnt 7
        sw_a = 1'b1; @(negedge clk); sw_a = 1'b0;
        clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
        chk("clr_in_pulse", 32'(cause), 4'b0010);
        repeat (6) @(negedge clk);
        res = 1'b1; #1;
        chk("midres_out", 32'(ro), 1);
        chk("midres_cause", 32'(cause), 4'b0001);
        @(negedge clk);
        res = 1'b0;
        run_high(1, n, d);
        chk("midres_len", n, 16);
        chk("midres_done", 32'(d), 1);
        chk("midres_cause_after", 32'(cause), 4'b0001);
        clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
        chk("clr_idle_2", 32'(cause), 0);

        // Held source: src[1] high for 40 cycles on the HOLD_MASK=2'b10 instance
        sel = 1; @(negedge clk);
        src_b[1] = 1'b1; hc = 0;
        repeat (40) begin @(negedge clk); hc += int'(ro); end
        src_b[1] = 1'b0;
        run_high(0, n, d);
        chk("hold_len", hc + n, 40);
        chk("hold_tail", n, 3);
        chk("hold_done", 32'(d), 1);
        chk("hold_cause", 32'(cause), 4'b1000);

        // Small configuration: NUM_SRC=4, PULSE_LEN=2, SYNC_STAGES=3
        sel = 2; @(negedge clk);
        res = 1'b1; @(negedge clk); res = 1'b0;
        run_high(1, n, d);
        chk("c_por_len", n, 2);
        chk("c_por_done", 32'(d), 1);
        chk("c_por_cause", 32'(cause), 6'b000001);

        sw_c = 1'b1;
        wait_rise(lat);
        chk("c_sw_lat", lat, 1);
        run_high(1, n, d);
        chk("c_sw_len", n, 2);

        src_c[2] = 1'b1;
        wait_rise(lat);
        chk("c_src2_lat", lat, 5);
        run_high(1, n, d);
        chk("c_src2_len", n, 2);
        chk("c_src2_cause", 32'(cause), 6'b010000);

        src_c[0] = 1'b1; src_c[3] = 1'b1;
        wait_rise(lat);
        chk("c_multi_lat", lat, 5);
        run_high(1, n, d);
        chk("c_multi_len", n, 2);
        chk("c_multi_cause", 32'(cause), 6'b100100);

        // Retrigger at the saturated count (k = 1): 1 + 1 + 2 cycles
        sw_c = 1'b1; @(negedge clk); sw_c = 1'b0;
        @(negedge clk);
        sw_c = 1'b1; @(negedge clk); sw_c = 1'b0;
        run_high(1, n, d);
        chk("c_sat_len", n + 2, 4);
        chk("c_sat_done", 32'(d), 1);
        chk("c_sat_cause", 32'(cause), 6'b000010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
